// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
// Supplies fallback FIFO width/depth macros when the enclosing build does not define them.
`ifndef FIFO_FF_DUT_WIDTH
`define FIFO_FF_DUT_WIDTH 8
`endif
`ifndef FIFO_FF_DUT_DEPTH
`define FIFO_FF_DUT_DEPTH 16
`endif

package fifo_wr_arb_pkg;

    localparam int DEF_NUM_REQ = 4;

`ifdef FIFO_WR_ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } arb_state_e;
`endif

endpackage

// File: rtl/fifo_wr_arb_rr_arb.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
// Produces a one-hot grant, the winning index and an any-grant flag.
module rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0] N_W = (PW+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [PW-1:0]      w_off;
    logic [PW:0]        w_sum;

    // Rotate so that the pointer position lands on bit 0; lowest set bit then wins.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
                o_any = 1'b1;
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= N_W) ? PW'(w_sum - N_W) : w_sum[PW-1:0];
    assign o_gnt = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO with occupancy-based credit.
// Optional burst lock (req_lock port, LOCK state) is built when FIFO_WR_ARB_LOCK_EN is defined.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = `FIFO_FF_DUT_WIDTH,
    parameter int DEPTH   = `FIFO_FF_DUT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic [$clog2(DEPTH):0]     fifo_occup,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data
`ifdef FIFO_WR_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]         req_lock
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int OW = $clog2(DEPTH) + 1;

    arb_state_e          r_state, w_state_next;
    logic [PW-1:0]       r_ptr, w_ptr_next;
    logic                r_wr_en;
    logic [WIDTH-1:0]    r_wr_data;
`ifdef FIFO_WR_ARB_LOCK_EN
    logic [PW-1:0]       r_owner, w_owner_next;
`endif

    logic [OW:0]         w_level;
    logic                w_credit;
    logic [NUM_REQ-1:0]  w_req_elig;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_idx_inc;
    logic                w_any;
    logic [WIDTH-1:0]    w_data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // The in-flight write is counted so a full FIFO can never be overrun.
    assign w_level  = {1'b0, fifo_occup} + {{OW{1'b0}}, r_wr_en};
    assign w_credit = (w_level < (OW+1)'(DEPTH));

    always_comb begin
        w_req_elig = req_vld;
`ifdef FIFO_WR_ARB_LOCK_EN
        if (r_state == LOCK) begin
            w_req_elig = req_vld & (NUM_REQ'(1) << r_owner);
        end
`endif
        if (!(w_credit && rst_n)) begin
            w_req_elig = '0;
        end
    end

    rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .i_req (w_req_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign req_rdy   = w_gnt;
    assign w_idx_inc = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
`ifdef FIFO_WR_ARB_LOCK_EN
        w_owner_next = r_owner;
`endif
        if (w_any) begin
            w_state_next = GRANT;
            w_ptr_next   = w_idx_inc;
`ifdef FIFO_WR_ARB_LOCK_EN
            // A locked accept keeps the pointer frozen until the burst ends.
            if (req_lock[w_idx]) begin
                w_state_next = LOCK;
                w_owner_next = w_idx;
                w_ptr_next   = r_ptr;
            end
`endif
        end else begin
            w_state_next = IDLE;
`ifdef FIFO_WR_ARB_LOCK_EN
            if ((r_state == LOCK) && req_vld[r_owner]) begin
                w_state_next = LOCK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
`ifdef FIFO_WR_ARB_LOCK_EN
            r_owner   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_wr_en <= w_any;
            if (w_any) begin
                r_wr_data <= w_data_arr[w_idx];
            end
`ifdef FIFO_WR_ARB_LOCK_EN
            r_owner <= w_owner_next;
`endif
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter WIDTH, default `FIFO_FF_DUT_WIDTH, data width per requester.
REQ-003 Parameter DEPTH, default `FIFO_FF_DUT_DEPTH, depth of the downstream FIFO.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port req_vld  input  NUM_REQ  per-requester write request.
REQ-007 Port req_data  input  NUM_REQ*WIDTH  per-requester data; requester i owns bits [i*WIDTH +: WIDTH].
REQ-008 Port req_rdy  output  NUM_REQ  one-hot-or-zero accept; transfer when req_vld[i] & req_rdy[i].
REQ-009 Port fifo_occup  input  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 Port fifo_wr_en  output  1  registered FIFO write strobe.
REQ-011 Port fifo_wr_data  output  WIDTH  registered FIFO write data.
REQ-012 Port req_lock  input  NUM_REQ  burst-lock request; present only with FIFO_WR_ARB_LOCK_EN.

Function
REQ-013 req_rdy SHALL be combinational from req_vld, round-robin pointer, state and credit; at most one bit set.
REQ-014 Credit SHALL exist when fifo_occup + fifo_wr_en < DEPTH (width-extended by one bit, no overflow); no credit -> req_rdy = 0.
REQ-015 Accepted data SHALL appear on fifo_wr_data with fifo_wr_en = 1 exactly one cycle after the accept edge; otherwise fifo_wr_en = 0 and fifo_wr_data holds its last value.
REQ-016 Round-robin: the winner is the first requester with req_vld set searching from pointer ptr upward with wrap; after an accept by requester i, ptr = (i+1) mod NUM_REQ.
REQ-017 ptr SHALL not change on cycles with no accept.
REQ-018 States: IDLE (no req_vld or no credit), GRANT (accept issued), LOCK (lock build only); IDLE->GRANT on any req_vld with credit; GRANT->IDLE when no req_vld or no credit.
REQ-019 Sustained throughput SHALL be one accept per cycle while credit exists; requesters alternate fairly under contention (N active -> each served once every N accepts).
REQ-020 Occupancy DEPTH-1 with fifo_wr_en = 1: credit is 0, no accept that cycle, no FIFO overflow ever.
REQ-021 req_vld dropped without accept SHALL not move ptr and SHALL not generate a write.

Reset
REQ-022 On rst_n low, asynchronously: fifo_wr_en = 0, fifo_wr_data = 0, ptr = 0, state = IDLE, lock owner cleared; req_rdy = 0 while rst_n is low.
REQ-023 Reset mid-burst SHALL discard the registered write; first accept after release SHALL follow the ptr = 0 search.

Configuration
REQ-024 Macro FIFO_WR_ARB_LOCK_EN: when defined, an accepted requester with req_lock[i] = 1 enters LOCK; in LOCK only requester i may be granted, ptr is frozen, and LOCK exits to GRANT/IDLE on the first accept with req_lock[i] = 0 (ptr then = i+1) or when req_vld[i] drops.
REQ-025 Without FIFO_WR_ARB_LOCK_EN: req_lock port and LOCK state are absent; pure round-robin.

Structure
REQ-026 Package fifo_wr_arb_pkg SHALL hold the state enum (IDLE, GRANT, LOCK) and default NUM_REQ.
REQ-027 Sub-module rr_arb SHALL implement the combinational round-robin pick (req vector, ptr -> one-hot grant, index).

Verification
REQ-028 Reset: hold rst_n = 0, all req_vld = 1 -> req_rdy = 0, fifo_wr_en = 0, fifo_wr_data = 0.
REQ-029 Contention: req_vld = 4'b1111, occup = 0 (DEPTH 16), data = 0xA0..0xA3 -> writes 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles.
REQ-030 Backpressure: occup = 15, one prior write pending -> no accept; occup falls to 14 with fifo_wr_en = 0 -> one accept resumes.
REQ-031 Sparse: only req_vld[2] = 1 for 3 cycles -> three writes from requester 2, ptr = 3 after.
REQ-032 Lock (FIFO_WR_ARB_LOCK_EN): req_vld = 4'b0011, req_lock[1] = 1 for 4 accepts -> requester 1 written 4 times before requester 0.
REQ-033 Mid-operation reset: assert rst_n = 0 during continuous writes -> fifo_wr_en = 0 immediately, first post-reset write from requester 0.
